// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / program loader) arbiter in front of a 16x8
// synchronous RAM, with a loader exclusive-lock mode and a self-timed clear
// sequence that fills the whole RAM with CLR_VAL.
module mem_arbiter #(
    parameter int          RR_MODE = 1,      // 1 = round-robin, 0 = CPU always wins
    parameter logic [7:0]  CLR_VAL = 8'h00   // word written everywhere by a clear
) (
    input  logic        CLK,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,

    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [3:0]  ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [7:0]  ld_rdata,

    input  logic        ld_lock,
    input  logic        clr,
    output logic        busy,
    output logic        cpu_hold
);

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    localparam logic [1:0] S_SERVE  = 2'b00;
    localparam logic [1:0] S_LOCKED = 2'b01;
    localparam logic [1:0] S_CLEAR  = 2'b10;

    // State and storage
    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic           r_last_ld;      // 1: loader won the most recent grant
    logic [AW-1:0]  r_clr_cnt;
    logic [DW-1:0]  r_mem [DEPTH];

    logic           r_cpu_rvalid;
    logic [DW-1:0]  r_cpu_rdata;
    logic           r_ld_rvalid;
    logic [DW-1:0]  r_ld_rdata;

    // Arbitration and RAM write-port signals
    logic           w_cpu_gnt;
    logic           w_ld_gnt;
    logic           w_locked_hold;
    logic           w_serve_rules;
    logic           w_in_clear;
    logic           w_clr_start;
    logic           w_cpu_rd;
    logic           w_ld_rd;
    logic           w_mem_we;
    logic [AW-1:0]  w_mem_waddr;
    logic [DW-1:0]  w_mem_wdata;

    // Lock is honoured only while ld_lock stays high; the cycle it drops
    // already arbitrates like SERVE.
    assign w_locked_hold = (r_state == S_LOCKED) && ld_lock;
    assign w_serve_rules = (r_state == S_SERVE) || ((r_state == S_LOCKED) && !ld_lock);
    assign w_in_clear    = (r_state == S_CLEAR);
    assign w_clr_start   = clr && !w_in_clear;

    // Grant decode: lock owner, then round-robin / fixed priority on conflict
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ld_gnt  = 1'b0;
        if (w_locked_hold) begin
            w_ld_gnt = ld_req;
        end else if (w_serve_rules) begin
            if (cpu_req && ld_req) begin
                if ((RR_MODE != 0) && !r_last_ld) begin
                    w_ld_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = 1'b1;
                end
            end else begin
                w_cpu_gnt = cpu_req;
                w_ld_gnt  = ld_req;
            end
        end
    end

    assign w_cpu_rd = w_cpu_gnt && !cpu_we;
    assign w_ld_rd  = w_ld_gnt  && !ld_we;

    // Next-state logic; a clear request outranks lock entry and lock release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SERVE: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_ld_gnt && ld_lock) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                end else if (!ld_lock) begin
                    w_state_nxt = S_SERVE;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_SERVE;
                end
            end
            default: begin
                w_state_nxt = S_SERVE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_SERVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Last-winner pointer, moves only when someone is granted
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_last_ld <= 1'b1;
        end else if (w_cpu_gnt) begin
            r_last_ld <= 1'b0;
        end else if (w_ld_gnt) begin
            r_last_ld <= 1'b1;
        end
    end

    // Clear address counter: zeroed on entry, free-running (wrapping) in CLEAR
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (w_clr_start) begin
            r_clr_cnt <= '0;
        end else if (w_in_clear) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // Single RAM write port: clear sweep, else whichever port holds the grant
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        if (w_in_clear) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_cnt;
            w_mem_wdata = CLR_VAL;
        end else if (w_cpu_gnt && cpu_we) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = cpu_addr;
            w_mem_wdata = cpu_wdata;
        end else if (w_ld_gnt && ld_we) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = ld_addr;
            w_mem_wdata = ld_wdata;
        end
    end

    // RAM array; deliberately not reset so contents survive reset
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // CPU read return: one-cycle rvalid pulse, data held between reads
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_rd;
            if (w_cpu_rd) begin
                r_cpu_rdata <= r_mem[cpu_addr];
            end
        end
    end

    // Loader read return: same behaviour as the CPU side
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ld_rvalid <= 1'b0;
            r_ld_rdata  <= '0;
        end else begin
            r_ld_rvalid <= w_ld_rd;
            if (w_ld_rd) begin
                r_ld_rdata <= r_mem[ld_addr];
            end
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign ld_gnt     = w_ld_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign ld_rvalid  = r_ld_rvalid;
    assign ld_rdata   = r_ld_rdata;
    assign busy       = w_in_clear;
    assign cpu_hold   = (r_state == S_LOCKED) || w_in_clear;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance carries most checks,
// a fixed-priority instance shares the same stimulus for the priority check.
module tb_mem_arbiter;

    logic       CLK = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ld_req, ld_we, ld_lock, clr;
    logic [3:0] cpu_addr, ld_addr;
    logic [7:0] cpu_wdata, ld_wdata;

    logic       rr_cpu_gnt, rr_cpu_rvalid, rr_ld_gnt, rr_ld_rvalid, rr_busy, rr_cpu_hold;
    logic [7:0] rr_cpu_rdata, rr_ld_rdata;
    logic       fp_cpu_gnt, fp_cpu_rvalid, fp_ld_gnt, fp_ld_rvalid, fp_busy, fp_cpu_hold;
    logic [7:0] fp_cpu_rdata, fp_ld_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.RR_MODE(1), .CLR_VAL(8'h00)) u_rr (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(rr_cpu_gnt), .cpu_rvalid(rr_cpu_rvalid), .cpu_rdata(rr_cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(rr_ld_gnt), .ld_rvalid(rr_ld_rvalid), .ld_rdata(rr_ld_rdata),
        .ld_lock(ld_lock), .clr(clr), .busy(rr_busy), .cpu_hold(rr_cpu_hold)
    );

    mem_arbiter #(.RR_MODE(0), .CLR_VAL(8'h00)) u_fp (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(fp_cpu_gnt), .cpu_rvalid(fp_cpu_rvalid), .cpu_rdata(fp_cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(fp_ld_gnt), .ld_rvalid(fp_ld_rvalid), .ld_rdata(fp_ld_rdata),
        .ld_lock(ld_lock), .clr(clr), .busy(fp_busy), .cpu_hold(fp_cpu_hold)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Global time guard
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_busy;
        int k;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = '0;  ld_wdata = '0;
        ld_lock = 1'b0; clr = 1'b0;

        // Reset values
        #2;
        chk1("rst_cpu_rvalid", rr_cpu_rvalid, 1'b0);
        chk8("rst_cpu_rdata",  rr_cpu_rdata,  8'h00);
        chk1("rst_ld_rvalid",  rr_ld_rvalid,  1'b0);
        chk8("rst_ld_rdata",   rr_ld_rdata,   8'h00);
        chk1("rst_busy",       rr_busy,       1'b0);
        chk1("rst_cpu_hold",   rr_cpu_hold,   1'b0);
        tick();
        reset = 1'b0;

        // Both request continuously: RR gives C,L,C,L; fixed priority always C
        cpu_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("rr_cpu_gnt", rr_cpu_gnt, (i % 2) == 0);
            chk1("rr_ld_gnt",  rr_ld_gnt,  (i % 2) == 1);
            chk1("fp_cpu_gnt", fp_cpu_gnt, 1'b1);
            chk1("fp_ld_gnt",  fp_ld_gnt,  1'b0);
            tick();
        end
        cpu_req = 1'b0; ld_req = 1'b0;

        // CPU alone: write 2A to addr 3 then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'h2A;
        #1 chk1("wr_gnt_same_cycle", rr_cpu_gnt, 1'b1);
        chk1("wr_ld_gnt_low", rr_ld_gnt, 1'b0);
        tick();
        cpu_we = 1'b0;
        #1 chk1("rd_gnt_same_cycle", rr_cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        #1 chk1("rd_rvalid", rr_cpu_rvalid, 1'b1);
        chk8("rd_rdata", rr_cpu_rdata, 8'h2A);
        tick();
        chk1("rvalid_one_cycle", rr_cpu_rvalid, 1'b0);
        chk8("rdata_held", rr_cpu_rdata, 8'h2A);

        // Write then read same address on consecutive cycles
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'h5C;
        tick();
        cpu_we = 1'b0;
        tick();
        cpu_req = 1'b0;
        #1 chk8("wr_then_rd", rr_cpu_rdata, 8'h5C);

        // Loader lock: CPU stalled while held, granted the cycle lock drops
        ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b0; ld_addr = 4'd3;
        #1 chk1("lock_ld_gnt", rr_ld_gnt, 1'b1);
        tick();
        ld_req = 1'b0;
        #1 chk1("lock_ld_rvalid", rr_ld_rvalid, 1'b1);
        chk8("lock_ld_rdata", rr_ld_rdata, 8'h2A);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("locked_cpu_gnt",  rr_cpu_gnt,  1'b0);
            chk1("locked_cpu_hold", rr_cpu_hold, 1'b1);
            tick();
        end
        ld_lock = 1'b0;
        #1 chk1("unlock_cpu_gnt", rr_cpu_gnt, 1'b1);
        tick();
        cpu_req = 1'b0;
        #1 chk1("unlock_cpu_hold", rr_cpu_hold, 1'b0);
        chk8("unlock_rdata", rr_cpu_rdata, 8'h5C);

        // Fill with FF, then clear while a read is requested in the same cycle
        for (int i = 0; i < 16; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'(i); cpu_wdata = 8'hFF;
            tick();
        end
        cpu_we = 1'b0; cpu_addr = 4'd3; clr = 1'b1;
        #1 chk1("clr_req_gnt", rr_cpu_gnt, 1'b1);
        tick();
        clr = 1'b0;
        #1 chk1("pre_clear_rvalid", rr_cpu_rvalid, 1'b1);
        chk8("pre_clear_rdata", rr_cpu_rdata, 8'hFF);
        n_busy = 0;
        k = 0;
        while (rr_busy && k < 40) begin
            n_busy++;
            if (k == 0) begin
                chk1("clear_cpu_gnt",  rr_cpu_gnt,  1'b0);
                chk1("clear_cpu_hold", rr_cpu_hold, 1'b1);
            end
            clr = (k == 3);
            k++;
            tick();
            #1;
        end
        clr = 1'b0;
        chk8("busy_cycles", 8'(n_busy), 8'd16);
        for (int i = 0; i < 16; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'(i);
            tick();
            #1 chk8("cleared_rd", rr_cpu_rdata, 8'h00);
        end
        cpu_req = 1'b0;

        // Reset in clear cycle 5 aborts the sweep
        for (int i = 0; i < 16; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'(i); cpu_wdata = 8'hFF;
            tick();
        end
        cpu_req = 1'b0; cpu_we = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        #1 chk1("abort_busy_before", rr_busy, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        #1 chk1("abort_busy", rr_busy, 1'b0);
        chk1("abort_cpu_hold", rr_cpu_hold, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'(i);
            tick();
            #1 chk8("abort_rd", rr_cpu_rdata, (i < 5) ? 8'h00 : 8'hFF);
        end
        cpu_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_MODE, default 1, meaning 1 = round-robin and 0 = fixed CPU priority.
REQ-002 SHALL have parameter CLR_VAL, default 8'h00, meaning the word written to every location by the clear sequence.
REQ-003 SHALL have port CLK  input  1  clock, all state updated on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_req  input  1  CPU access request, held until granted.
REQ-006 SHALL have port cpu_we  input  1  CPU write (1) or read (0).
REQ-007 SHALL have port cpu_addr  input  4  CPU word address.
REQ-008 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-009 SHALL have port cpu_gnt  output  1  CPU access accepted this cycle.
REQ-010 SHALL have port cpu_rvalid  output  1  CPU read data valid.
REQ-011 SHALL have port cpu_rdata  output  8  CPU read data.
REQ-012 SHALL have ports ld_req, ld_we, ld_addr[4], ld_wdata[8], ld_gnt, ld_rvalid, ld_rdata[8], with the same directions and meaning as the CPU ports, for the program loader.
REQ-013 SHALL have port ld_lock  input  1  loader requests exclusive ownership.
REQ-014 SHALL have port clr  input  1  one-cycle pulse that starts a memory clear.
REQ-015 SHALL have port busy  output  1  clear sequence in progress.
REQ-016 SHALL have port cpu_hold  output  1  CPU must stall because loader lock is held or a clear is running.

Function
REQ-017 SHALL contain a 16x8 RAM, written synchronously and read synchronously with 1-cycle latency.
REQ-018 SHALL compute cpu_gnt and ld_gnt combinationally from the requests, the lock, the FSM state and the last-winner pointer, and SHALL never assert both in one cycle.
REQ-019 SHALL perform the access on the rising edge at which req&gnt is true: a write commits wdata to addr; a read registers mem[addr] into that port's rdata and asserts that port's rvalid for exactly the next cycle.
REQ-020 SHALL hold rdata at its last value when rvalid is low.
REQ-021 SHALL, with a single requester, grant it in the same cycle (0 wait states).
REQ-022 SHALL, when both request and RR_MODE=1, grant the port not granted most recently; the pointer updates only on a grant.
REQ-023 SHALL, when both request and RR_MODE=0, always grant the CPU.
REQ-024 SHALL implement FSM states SERVE, LOCKED and CLEAR.
REQ-025 SHALL transition SERVE->LOCKED on an ld grant with ld_lock=1.
REQ-026 SHALL, in LOCKED, grant only the loader and hold cpu_gnt=0.
REQ-027 SHALL transition LOCKED->SERVE in the first cycle ld_lock is sampled low; in that same cycle arbitration follows SERVE rules.
REQ-028 SHALL, on clr in SERVE or LOCKED, enter CLEAR on the next edge, load a 4-bit counter to 0, and drop any lock.
REQ-029 SHALL, in CLEAR, write CLR_VAL to mem[counter] each cycle and increment the counter, hold both gnt at 0 and busy=1, and return to SERVE after writing address 15 (exactly 16 cycles); the counter wraps 15->0 without side effect.
REQ-030 SHALL ignore clr while in CLEAR.
REQ-031 SHALL, when clr and a request occur in the same cycle, still grant and perform the request, and begin CLEAR afterwards.
REQ-032 SHALL deliver a read granted in the cycle before CLEAR with rvalid as normal.
REQ-033 SHALL drive cpu_hold = (state==LOCKED) | (state==CLEAR), combinationally.
REQ-034 SHALL, when a write and a read target the same address in consecutive cycles, return the newly written data to the read.

Reset
REQ-035 SHALL, on reset, force state=SERVE, pointer=loader-last (CPU wins the first conflict), counter=0, cpu_rvalid=ld_rvalid=0, cpu_rdata=ld_rdata=0, busy=0 and cpu_hold=0, with gnt outputs following REQ-018.
REQ-036 SHALL leave RAM contents unchanged by reset.
REQ-037 SHALL, on reset asserted mid-CLEAR, abort the clear immediately and leave the remaining locations unmodified.

Verification
REQ-038 SHALL verify: CPU alone writes 8'h2A to addr 3, then reads addr 3 -> cpu_gnt the same cycle both times, cpu_rvalid one cycle after the read grant with cpu_rdata=8'h2A.
REQ-039 SHALL verify: RR_MODE=1 with both requesting continuously for 4 cycles after reset -> grants CPU, LD, CPU, LD.
REQ-040 SHALL verify: RR_MODE=0 with both requesting continuously -> CPU granted every cycle and ld_gnt stays 0.
REQ-041 SHALL verify: loader granted with ld_lock=1, then CPU requests for 5 cycles -> cpu_gnt=0 and cpu_hold=1 throughout; cpu_gnt is asserted in the cycle ld_lock falls.
REQ-042 SHALL verify: after writing 8'hFF to all 16 locations, pulse clr -> busy=1 for exactly 16 cycles, then reads of addr 0..15 all return 8'h00.
REQ-043 SHALL verify: reset asserted at clear cycle 5 -> busy=0 immediately, addr 0..4 read 8'h00 and addr 5..15 read 8'hFF.
